// File: rtl/address_demux2.sv
// Two-destination address demultiplexer with a one-entry skid buffer per output.
// Optional per-destination transfer counters are built when ADDRESS_DEMUX2_STATS_EN is defined.
module address_demux2 #(
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] IADDR,
  input  logic                  IVALID,
  input  logic                  SELECT,
  output logic                  IREADY,
  output logic [ADDR_WIDTH-1:0] OADDR1,
  output logic [ADDR_WIDTH-1:0] OADDR2,
  output logic                  OVALID1,
  output logic                  OVALID2,
  input  logic                  OREADY1,
  input  logic                  OREADY2
`ifdef ADDRESS_DEMUX2_STATS_EN
  ,
  output logic [15:0]           CNT1,
  output logic [15:0]           CNT2
`endif
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  buf_state_e            state1_q, state1_d;
  buf_state_e            state2_q, state2_d;
  logic [ADDR_WIDTH-1:0] oaddr1_q, oaddr1_d;
  logic [ADDR_WIDTH-1:0] oaddr2_q, oaddr2_d;

  logic ready1_c;
  logic ready2_c;
  logic in_xfer1_c;
  logic in_xfer2_c;
  logic out_xfer1_c;
  logic out_xfer2_c;

  // A buffer can accept when empty or when it is being drained on this edge.
  always_comb begin
    ready1_c    = (state1_q == EMPTY) || OREADY1;
    ready2_c    = (state2_q == EMPTY) || OREADY2;
    IREADY      = SELECT ? ready2_c : ready1_c;
    in_xfer1_c  = IVALID && !SELECT && ready1_c;
    in_xfer2_c  = IVALID &&  SELECT && ready2_c;
    out_xfer1_c = (state1_q == FULL) && OREADY1;
    out_xfer2_c = (state2_q == FULL) && OREADY2;
  end

  // Destination 1 buffer next state.
  always_comb begin
    state1_d = state1_q;
    oaddr1_d = oaddr1_q;
    case (state1_q)
      EMPTY: begin
        if (in_xfer1_c) begin
          state1_d = FULL;
          oaddr1_d = IADDR;
        end
      end
      FULL: begin
        if (in_xfer1_c) begin
          state1_d = FULL;
          oaddr1_d = IADDR;
        end else if (out_xfer1_c) begin
          state1_d = EMPTY;
        end
      end
      default: state1_d = EMPTY;
    endcase
  end

  // Destination 2 buffer next state.
  always_comb begin
    state2_d = state2_q;
    oaddr2_d = oaddr2_q;
    case (state2_q)
      EMPTY: begin
        if (in_xfer2_c) begin
          state2_d = FULL;
          oaddr2_d = IADDR;
        end
      end
      FULL: begin
        if (in_xfer2_c) begin
          state2_d = FULL;
          oaddr2_d = IADDR;
        end else if (out_xfer2_c) begin
          state2_d = EMPTY;
        end
      end
      default: state2_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state1_q <= EMPTY;
      state2_q <= EMPTY;
      oaddr1_q <= '0;
      oaddr2_q <= '0;
    end else begin
      state1_q <= state1_d;
      state2_q <= state2_d;
      oaddr1_q <= oaddr1_d;
      oaddr2_q <= oaddr2_d;
    end
  end

  assign OVALID1 = (state1_q == FULL);
  assign OVALID2 = (state2_q == FULL);
  assign OADDR1  = oaddr1_q;
  assign OADDR2  = oaddr2_q;

`ifdef ADDRESS_DEMUX2_STATS_EN
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;

  // Saturating per-destination accepted-transfer counters.
  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if (in_xfer1_c && (cnt1_q != {CNT_W{1'b1}})) begin
      cnt1_d = cnt1_q + CNT_W'(1);
    end
    if (in_xfer2_c && (cnt2_q != {CNT_W{1'b1}})) begin
      cnt2_d = cnt2_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

  assign CNT1 = cnt1_q;
  assign CNT2 = cnt2_q;
`endif

endmodule

// File: tb/tb_address_demux2.sv
// Directed self-checking bench for address_demux2 (stats counters checked when
// ADDRESS_DEMUX2_STATS_EN is defined).
module tb_address_demux2;

  localparam int unsigned AW = 11;

  logic          CLK;
  logic          RST;
  logic [AW-1:0] IADDR;
  logic          IVALID;
  logic          SELECT;
  logic          IREADY;
  logic [AW-1:0] OADDR1;
  logic [AW-1:0] OADDR2;
  logic          OVALID1;
  logic          OVALID2;
  logic          OREADY1;
  logic          OREADY2;
`ifdef ADDRESS_DEMUX2_STATS_EN
  logic [15:0]   CNT1;
  logic [15:0]   CNT2;
`endif

  int n_total;
  int n_pass;

  address_demux2 #(.ADDR_WIDTH(AW)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .IADDR   (IADDR),
    .IVALID  (IVALID),
    .SELECT  (SELECT),
    .IREADY  (IREADY),
    .OADDR1  (OADDR1),
    .OADDR2  (OADDR2),
    .OVALID1 (OVALID1),
    .OVALID2 (OVALID2),
    .OREADY1 (OREADY1),
    .OREADY2 (OREADY2)
`ifdef ADDRESS_DEMUX2_STATS_EN
    ,
    .CNT1    (CNT1),
    .CNT2    (CNT2)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    RST     = 1'b1;
    IADDR   = '0;
    IVALID  = 1'b0;
    SELECT  = 1'b0;
    OREADY1 = 1'b0;
    OREADY2 = 1'b0;

    // Reset state
    #12;
    check("rst_ovalid1", 32'(OVALID1), 32'h0);
    check("rst_ovalid2", 32'(OVALID2), 32'h0);
    check("rst_oaddr1",  32'(OADDR1),  32'h0);
    check("rst_oaddr2",  32'(OADDR2),  32'h0);
`ifdef ADDRESS_DEMUX2_STATS_EN
    check("rst_cnt1", 32'(CNT1), 32'h0);
    check("rst_cnt2", 32'(CNT2), 32'h0);
`endif
    RST = 1'b0;
    #1;
    check("post_rst_iready", 32'(IREADY), 32'h1);

    // Single transfer to port 1, drained immediately
    OREADY1 = 1'b1;
    IVALID  = 1'b1;
    SELECT  = 1'b0;
    IADDR   = 11'h123;
    tick();
    IVALID = 1'b0;
    check("s1_ovalid1", 32'(OVALID1), 32'h1);
    check("s1_oaddr1",  32'(OADDR1),  32'h123);
    check("s1_ovalid2", 32'(OVALID2), 32'h0);
    tick();
    check("s1_drained", 32'(OVALID1), 32'h0);
    check("s1_ovalid2_still0", 32'(OVALID2), 32'h0);

    // IVALID low: SELECT/IADDR ignored
    SELECT = 1'b1;
    IADDR  = 11'h3C3;
    tick();
    check("idle_ovalid2", 32'(OVALID2), 32'h0);
    check("idle_oaddr2",  32'(OADDR2),  32'h0);

    // Port 2 stalled: second beat back-pressured
    OREADY2 = 1'b0;
    IVALID  = 1'b1;
    SELECT  = 1'b1;
    IADDR   = 11'h7FF;
    #1;
    check("s2_iready_first", 32'(IREADY), 32'h1);
    tick();
    IADDR = 11'h001;
    #1;
    check("s2_ovalid2", 32'(OVALID2), 32'h1);
    check("s2_oaddr2",  32'(OADDR2),  32'h7FF);
    check("s2_iready_blocked", 32'(IREADY), 32'h0);
    tick();
    check("s2_hold_oaddr2", 32'(OADDR2), 32'h7FF);
    check("s2_hold_ovalid2", 32'(OVALID2), 32'h1);

    // Port 2 stalled does not block port 1
    SELECT = 1'b0;
    IADDR  = 11'h055;
    #1;
    check("s3_iready", 32'(IREADY), 32'h1);
    tick();
    check("s3_oaddr1",  32'(OADDR1),  32'h055);
    check("s3_ovalid1", 32'(OVALID1), 32'h1);
    check("s3_oaddr2_held", 32'(OADDR2), 32'h7FF);

    // Release port 2: 0x001 follows with no bubble
    SELECT  = 1'b1;
    IADDR   = 11'h001;
    OREADY2 = 1'b1;
    #1;
    check("s2_iready_release", 32'(IREADY), 32'h1);
    tick();
    IVALID = 1'b0;
    check("s2_oaddr2_next",  32'(OADDR2),  32'h001);
    check("s2_ovalid2_next", 32'(OVALID2), 32'h1);
    check("s3_port1_drained", 32'(OVALID1), 32'h0);
    tick();
    check("s2_drained", 32'(OVALID2), 32'h0);

    // Port 1 simultaneous drain and refill
    OREADY1 = 1'b0;
    IVALID  = 1'b1;
    SELECT  = 1'b0;
    IADDR   = 11'h010;
    tick();
    check("s4_oaddr1_first", 32'(OADDR1), 32'h010);
    OREADY1 = 1'b1;
    IADDR   = 11'h020;
    #1;
    check("s4_iready", 32'(IREADY), 32'h1);
    tick();
    IVALID = 1'b0;
    check("s4_ovalid1", 32'(OVALID1), 32'h1);
    check("s4_oaddr1",  32'(OADDR1),  32'h020);
    tick();
    check("s4_drained", 32'(OVALID1), 32'h0);

    // Both full, asynchronous reset between edges
    OREADY1 = 1'b0;
    OREADY2 = 1'b0;
    IVALID  = 1'b1;
    SELECT  = 1'b0;
    IADDR   = 11'h0AA;
    tick();
    SELECT = 1'b1;
    IADDR  = 11'h0BB;
    tick();
    IVALID = 1'b0;
    check("s5_ovalid1_full", 32'(OVALID1), 32'h1);
    check("s5_ovalid2_full", 32'(OVALID2), 32'h1);
    #2;
    RST = 1'b1;
    #1;
    check("s5_async_ovalid1", 32'(OVALID1), 32'h0);
    check("s5_async_ovalid2", 32'(OVALID2), 32'h0);
    check("s5_async_oaddr1",  32'(OADDR1),  32'h0);
    @(negedge CLK);
    RST = 1'b0;
    tick();
    check("s5_rel_ovalid1", 32'(OVALID1), 32'h0);
    check("s5_rel_ovalid2", 32'(OVALID2), 32'h0);
    check("s5_rel_iready",  32'(IREADY),  32'h1);

`ifdef ADDRESS_DEMUX2_STATS_EN
    // Counter saturation on destination 2
    OREADY2 = 1'b1;
    IVALID  = 1'b1;
    SELECT  = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      IADDR = AW'(i);
      tick();
    end
    IVALID = 1'b0;
    tick();
    check("cnt2_saturated", 32'(CNT2), 32'hFFFF);
    check("cnt1_zero",      32'(CNT1), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/address_demux2.md
ADDRESS_DEMUX2 -- requirements
Module: address_demux2

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 11, giving the width of every address port.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port RST, input, 1, reset; it is asynchronous and active-high.
REQ-004 The block SHALL have port IADDR, input, ADDR_WIDTH, the incoming address.
REQ-005 The block SHALL have port IVALID, input, 1, which is high when IADDR and SELECT are valid.
REQ-006 The block SHALL have port SELECT, input, 1, the destination: 0 routes to port 1 and 1 routes to port 2.
REQ-007 The block SHALL have port IREADY, output, 1, which is high when the block can accept the input this cycle.
REQ-008 The block SHALL have ports OADDR1 and OADDR2, output, ADDR_WIDTH, the buffered address for each destination.
REQ-009 The block SHALL have ports OVALID1 and OVALID2, output, 1, which are high while the corresponding output buffer holds an entry.
REQ-010 The block SHALL have ports OREADY1 and OREADY2, input, 1, the downstream consumer's acceptance for each destination.
REQ-011 When the stats feature is enabled, the block SHALL have ports CNT1 and CNT2, output, 16, the count of transfers accepted for each destination.

Function
REQ-012 Each destination SHALL own a one-entry buffer with two states, EMPTY and FULL; OVALIDn SHALL equal (state == FULL).
REQ-013 A transfer SHALL occur on an input when IVALID and IREADY are both high at a rising CLK edge.
REQ-014 A transfer SHALL occur on an output n when OVALIDn and OREADYn are both high at a rising CLK edge.
REQ-015 IREADY SHALL equal (the selected buffer is EMPTY) or (the selected buffer is FULL and OREADYn is high).
- IREADY is combinational from SELECT and OREADYn.
- It SHALL be low only when the selected buffer cannot accept.
REQ-016 Latency SHALL be one cycle: an input transfer at edge k SHALL make OVALIDn high, with OADDRn equal to the captured IADDR, from edge k onward.
REQ-017 An input transfer SHALL fill only the selected buffer; the non-selected buffer SHALL be unaffected.
REQ-018 Buffer transitions SHALL be:
- EMPTY to FULL on an input transfer.
- FULL to EMPTY on an output transfer with no input transfer to the same buffer.
- FULL to FULL with new data when an output transfer and an input transfer to the same buffer happen on the same edge.
REQ-019 While OVALIDn is high and OREADYn is low, OADDRn SHALL hold stable.
REQ-020 While the buffer is EMPTY, OADDRn SHALL hold its last value; its content is don't-care.
REQ-021 When IVALID is low, SELECT and IADDR SHALL be ignored and no state SHALL change except draining.
REQ-022 The two outputs SHALL drain independently; one port stalled SHALL NOT block inputs routed to the other port.
REQ-023 No input SHALL ever be dropped or duplicated; ordering within each destination SHALL be preserved.

Reset
REQ-024 While RST is high, both buffers SHALL be EMPTY, OVALID1 and OVALID2 SHALL be 0, OADDR1 and OADDR2 SHALL be 0, and CNT1 and CNT2 SHALL be 0.
REQ-025 RST asserted mid-operation SHALL discard buffered entries immediately, without waiting for a clock edge.
REQ-026 On the first edge after RST deasserts, the block SHALL be ready to accept, so IREADY is 1.

Configuration
REQ-027 The macro ADDRESS_DEMUX2_STATS_EN SHALL control the stats feature.
- Defined: CNT1 and CNT2 exist; each SHALL increment by 1 on every input transfer to its destination and saturate at 16'hFFFF.
- Not defined: CNT1, CNT2 and their logic SHALL be absent, and the rest of the behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Reset release, then IVALID=1, SELECT=0, IADDR=0x123 for one cycle, with OREADY1=1 -> OVALID1=1 with OADDR1=0x123 for exactly one cycle; OVALID2 stays 0.
- OREADY2=0; send 0x7FF with SELECT=1, then 0x001 with SELECT=1 -> second cycle IREADY=0; OADDR2 holds 0x7FF; after OREADY2=1, 0x001 follows.
- Port 2 stalled and FULL; send 0x055 with SELECT=0 -> accepted, IREADY=1, OADDR1=0x055 next cycle.
- Port 1 FULL with 0x010, OREADY1=1, input 0x020 with SELECT=0 on the same edge -> OVALID1 stays 1 and OADDR1 becomes 0x020 with no bubble.
- Both buffers FULL, assert RST between edges -> OVALID1 and OVALID2 drop to 0 immediately; no stale output after release.
- With ADDRESS_DEMUX2_STATS_EN defined, 70000 transfers with SELECT=1 -> CNT2=16'hFFFF and CNT1=0.
